adxl362_controller: RTL and testbench

SPI master controller that sequences register write, register read and FIFO-read transactions to the ADXL362 accelerometer on the PmodACL2. It sits between the user logic and the ADXL362 SPI pins: it takes one command request at a time, generates mode-0 SCLK/nCS/MOSI, and returns read bytes as one-cycle strobes. It is the master counterpart of the ADXL362 slave model used in the behavioral bench.

---
 rtl/adxl362_controller.sv | 279 +++++++++++++++++++++++++++
 tb/tb_adxl362_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_controller.sv
// adxl362_controller
// SPI mode-0 master that sequences register write (0x0A), register read (0x0B)
// and FIFO read (0x0D) transactions to an ADXL362 accelerometer. It accepts one
// command at a time and returns each received data byte as a one-cycle strobe.
//
// Optional feature: define ADXL362_CTRL_CMD_CHECK_EN to reject any command byte
// other than 0x0A/0x0B/0x0D. A rejected command pulses err and starts no SPI
// activity. When the macro is undefined, every command is accepted and runs as a
// read-format transaction.
//
// Parameters
//   CLK_DIV      clk_16mhz cycles per SCLK half-period (minimum 2)
// Ports
//   clk_16mhz    system clock, rising edge
//   rst          synchronous active-high reset
//   start        request strobe, taken only while busy=0
//   cmd          command byte
//   addr         register address, sent as {2'b00, addr}
//   length       data bytes per transaction (0 is treated as 1)
//   wr_data      next write byte, sampled on the edge that ends wr_data_req
//   wr_data_req  one-cycle request; wr_data is captured at the end of it
//   rd_data      last received data byte
//   rd_valid     one-cycle strobe, rd_data is new
//   busy         transaction in progress, including the nCS gap
//   done         one-cycle pulse in the cycle nCS returns high
//   err          one-cycle pulse on a rejected command
//   SCLK/MOSI/nCS/MISO  SPI pins
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | nCS high, waiting for start
// CS_SETUP   | nCS low, first MOSI bit presented, SCLK low one half-period
// SHIFT_CMD  | shifting the command byte
// SHIFT_ADDR | shifting the address byte (skipped for FIFO read)
// SHIFT_DATA | shifting data bytes until the byte counter expires
// CS_HOLD    | SCLK low, nCS held low one half-period after the last fall
// CS_GAP     | nCS high for two half-periods before returning to IDLE
module adxl362_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [5:0] addr,
    input  logic [3:0] length,
    input  logic [7:0] wr_data,
    output logic       wr_data_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       SCLK,
    output logic       MOSI,
    output logic       nCS,
    input  logic       MISO
);

    localparam int TW = $clog2(2 * CLK_DIV + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(2 * CLK_DIV - 1);

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_FIFO  = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_CMD,
        SHIFT_ADDR,
        SHIFT_DATA,
        CS_HOLD,
        CS_GAP
    } state_t;

    state_t state, state_nxt;

    logic [TW-1:0] tmr;
    logic [2:0]    bit_cnt;
    logic [3:0]    byte_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic [5:0]    addr_q;
    logic          wr_q;
    logic          fifo_q;
    logic          rd_pend;

    logic          tmr_tc;
    logic          shifting;
    logic          byte_end;
    logic          last_data;
    logic          cmd_ok;
    logic [7:0]    next_byte;

    assign tmr_tc    = (tmr == '0);
    assign shifting  = (state == SHIFT_CMD) || (state == SHIFT_ADDR) || (state == SHIFT_DATA);
    // A byte ends on the falling SCLK edge of its eighth bit.
    assign byte_end  = shifting && tmr_tc && SCLK && (bit_cnt == 3'd0);
    assign last_data = (byte_cnt == 4'd1);

`ifdef ADXL362_CTRL_CMD_CHECK_EN
    localparam logic [7:0] CMD_READ = 8'h0B;
    assign cmd_ok = (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_FIFO);
`else
    assign cmd_ok = 1'b1;
`endif

    // wr_data is requested in the cycle before the edge that loads it into the
    // shift register, so the user sees the request while wr_data is sampled.
    assign wr_data_req = !rst && wr_q && byte_end &&
                         ((state == SHIFT_ADDR) || ((state == SHIFT_DATA) && !last_data));

    // Byte loaded into the transmit shift register at the end of the current byte.
    always_comb begin
        next_byte = 8'h00;
        case (state)
            SHIFT_CMD:  next_byte = fifo_q ? (wr_q ? wr_data : 8'h00) : {2'b00, addr_q};
            SHIFT_ADDR: next_byte = wr_q ? wr_data : 8'h00;
            SHIFT_DATA: next_byte = (wr_q && !last_data) ? wr_data : 8'h00;
            default:    next_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && cmd_ok) begin
                    state_nxt = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tmr_tc) begin
                    state_nxt = SHIFT_CMD;
                end
            end
            SHIFT_CMD: begin
                if (byte_end) begin
                    state_nxt = fifo_q ? SHIFT_DATA : SHIFT_ADDR;
                end
            end
            SHIFT_ADDR: begin
                if (byte_end) begin
                    state_nxt = SHIFT_DATA;
                end
            end
            SHIFT_DATA: begin
                if (byte_end && last_data) begin
                    state_nxt = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (tmr_tc) begin
                    state_nxt = CS_GAP;
                end
            end
            CS_GAP: begin
                if (tmr_tc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            tmr      <= '0;
            bit_cnt  <= 3'd7;
            byte_cnt <= 4'd1;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
            addr_q   <= 6'h00;
            wr_q     <= 1'b0;
            fifo_q   <= 1'b0;
            rd_pend  <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            nCS      <= 1'b1;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_pend  <= 1'b0;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= rx_sr;
            end
            if (!tmr_tc) begin
                tmr <= tmr - TW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (cmd_ok) begin
                            addr_q   <= addr;
                            wr_q     <= (cmd == CMD_WRITE);
                            fifo_q   <= (cmd == CMD_FIFO);
                            byte_cnt <= (length == 4'd0) ? 4'd1 : length;
                            bit_cnt  <= 3'd7;
                            tx_sr    <= cmd;
                            MOSI     <= cmd[7];
                            tmr      <= HALF_LOAD;
                            nCS      <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CS_SETUP: begin
                    // First rising edge of the transaction.
                    if (tmr_tc) begin
                        SCLK  <= 1'b1;
                        rx_sr <= {rx_sr[6:0], MISO};
                        tmr   <= HALF_LOAD;
                    end
                end
                SHIFT_CMD, SHIFT_ADDR, SHIFT_DATA: begin
                    if (tmr_tc) begin
                        tmr <= HALF_LOAD;
                        if (!SCLK) begin
                            SCLK  <= 1'b1;
                            rx_sr <= {rx_sr[6:0], MISO};
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                bit_cnt <= 3'd7;
                                tx_sr   <= next_byte;
                                MOSI    <= next_byte[7];
                                if (state == SHIFT_DATA) begin
                                    byte_cnt <= byte_cnt - 4'd1;
                                    rd_pend  <= !wr_q;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                                MOSI    <= tx_sr[6];
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (tmr_tc) begin
                        nCS  <= 1'b1;
                        done <= 1'b1;
                        MOSI <= 1'b0;
                        tmr  <= GAP_LOAD;
                    end
                end
                CS_GAP: begin
                    if (tmr_tc) begin
                        busy <= 1'b0;
                    end
                end
                default: begin
                    nCS  <= 1'b1;
                    SCLK <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adxl362_controller.sv
// Bench for adxl362_controller: a mode-0 slave model answers MISO, a monitor
// scoreboards MOSI bytes, rd_valid data/timing and wr_data_req handshakes.
module tb_adxl362_controller;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [5:0] addr = 6'h00;
    logic [3:0] length = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_data_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic       SCLK;
    logic       MOSI;
    logic       nCS;
    logic       MISO = 1'b0;

    adxl362_controller #(.CLK_DIV(CD)) dut (
        .clk_16mhz  (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .addr       (addr),
        .length     (length),
        .wr_data    (wr_data),
        .wr_data_req(wr_data_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .nCS        (nCS),
        .MISO       (MISO)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } rd_exp_t;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;

    logic [7:0] exp_mosi_q[$];
    logic [7:0] wr_src_q[$];
    rd_exp_t    exp_rd_q[$];
    logic [7:0] wr_bytes[16];
    logic [7:0] slave_data[16];

    int hdr_bits = 16;
    int rises = 0;
    int first_rise = -1;
    int wr_req_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_rel = -1;
    int mosi_viol = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc - t0);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Slave model and output monitor, sampled on the falling clock edge.
    initial begin
        logic       prev_sclk;
        logic       prev_ncs;
        logic       prev_mosi;
        logic [7:0] mosi_sr;
        logic [7:0] sb;
        int         bit_idx;
        int         mosi_bits;
        int         rel_b;
        int         kb;
        rd_exp_t    e;
        prev_sclk = 1'b0;
        prev_ncs  = 1'b1;
        prev_mosi = 1'b0;
        mosi_sr   = 8'h00;
        bit_idx   = 0;
        mosi_bits = 0;
        forever begin
            @(negedge clk);
            if (prev_ncs && !nCS) begin
                bit_idx = 0;
            end else if (prev_sclk && !SCLK) begin
                bit_idx++;
            end
            if (!nCS && SCLK && prev_sclk && (MOSI != prev_mosi)) begin
                mosi_viol++;
            end
            if (!nCS && !prev_sclk && SCLK) begin
                if (rises == 0) first_rise = cyc - t0;
                rises++;
                mosi_sr = {mosi_sr[6:0], MOSI};
                mosi_bits++;
                if (mosi_bits == 8) begin
                    mosi_bits = 0;
                    chk("mosi_byte_expected", exp_mosi_q.size() > 0, 1);
                    if (exp_mosi_q.size() > 0) chk("mosi_byte", mosi_sr, exp_mosi_q.pop_front());
                end
            end
            if (nCS) mosi_bits = 0;

            if (nCS) begin
                MISO = 1'b0;
            end else if (bit_idx < hdr_bits) begin
                MISO = 1'b1;
            end else begin
                rel_b = bit_idx - hdr_bits;
                kb = rel_b / 8;
                if (kb > 15) kb = 15;
                sb = slave_data[kb];
                MISO = sb[7 - (rel_b % 8)];
            end

            if (rd_valid) begin
                rd_cnt++;
                chk("rd_expected", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) begin
                    e = exp_rd_q.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_cycle", cyc - t0, e.c);
                end
            end
            if (wr_data_req) begin
                wr_req_cnt++;
                chk("wr_req_expected", wr_src_q.size() > 0, 1);
                if (wr_src_q.size() > 0) wr_data = wr_src_q.pop_front();
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_rel = cyc - t0;
            end
            prev_sclk = SCLK;
            prev_ncs  = nCS;
            prev_mosi = MOSI;
        end
    end

    task automatic run_txn(input logic [7:0] c, input logic [5:0] a, input logic [3:0] len, input int poke);
        int      n;
        int      hdr;
        int      nb;
        int      tdone;
        int      tbusy;
        bit      seen;
        rd_exp_t e;
        n   = (len == 4'd0) ? 1 : int'(len);
        hdr = (c == 8'h0D) ? 8 : 16;
        nb  = hdr + 8 * n;
        exp_mosi_q.push_back(c);
        if (c != 8'h0D) exp_mosi_q.push_back({2'b00, a});
        for (int j = 0; j < n; j++) begin
            if (c == 8'h0A) begin
                exp_mosi_q.push_back(wr_bytes[j]);
                wr_src_q.push_back(wr_bytes[j]);
            end else begin
                exp_mosi_q.push_back(8'h00);
                e.d = slave_data[j];
                e.c = 1 + 2 * CD * (hdr + 8 * j + 8) + 1;
                exp_rd_q.push_back(e);
            end
        end
        hdr_bits   = hdr;
        rises      = 0;
        first_rise = -1;
        wr_req_cnt = 0;
        rd_cnt     = 0;
        mosi_viol  = 0;

        @(negedge clk);
        start  = 1'b1;
        cmd    = c;
        addr   = a;
        length = len;
        t0     = cyc;
        @(negedge clk);
        start  = 1'b0;
        cmd    = 8'hFF;
        addr   = a ^ 6'h3F;
        length = len + 4'd3;
        chk("busy_cycle1", busy, 1);
        chk("ncs_cycle1", nCS, 0);

        seen  = 1'b0;
        tdone = -1;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clk);
            if (cyc - t0 == poke) begin
                start  = 1'b1;
                cmd    = 8'h0A;
                addr   = 6'h15;
                length = 4'd7;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen  = 1'b1;
                tdone = cyc - t0;
                chk("ncs_at_done", nCS, 1);
            end
        end
        chk("done_seen", seen, 1);
        chk("done_cycle", tdone, 1 + CD * (2 * nb + 1));

        seen  = 1'b0;
        tbusy = -1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (!busy) begin
                seen  = 1'b1;
                tbusy = cyc - t0;
            end
        end
        chk("busy_fall_seen", seen, 1);
        chk("busy_fall_cycle", tbusy, tdone + 2 * CD);
        chk("sclk_rises", rises, nb);
        chk("first_rise_cycle", first_rise, 1 + CD);
        chk("wr_req_count", wr_req_cnt, (c == 8'h0A) ? n : 0);
        chk("rd_valid_count", rd_cnt, (c == 8'h0A) ? 0 : n);
        chk("mosi_left", exp_mosi_q.size(), 0);
        chk("rd_left", exp_rd_q.size(), 0);
        chk("wr_left", wr_src_q.size(), 0);
        chk("mosi_stable", mosi_viol, 0);
        chk("ncs_idle", nCS, 1);
        exp_mosi_q.delete();
        exp_rd_q.delete();
        wr_src_q.delete();
    endtask

    initial begin
        int d0;
        int e0;
        int ncs_low;
        int busy_hi;

        repeat (3) @(negedge clk);
        chk("rst_ncs", nCS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_data_req", wr_data_req, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        wr_bytes[0] = 8'h02;
        run_txn(8'h0A, 6'h2D, 4'd1, -1);

        slave_data[0] = 8'hAD;
        run_txn(8'h0B, 6'h00, 4'd1, -1);

        slave_data[0] = 8'h11;
        slave_data[1] = 8'h22;
        slave_data[2] = 8'h33;
        slave_data[3] = 8'h44;
        run_txn(8'h0B, 6'h0E, 4'd4, -1);

        slave_data[0] = 8'($urandom);
        slave_data[1] = 8'($urandom);
        run_txn(8'h0D, 6'h00, 4'd2, -1);

        // Burst write with a start pulse while busy that must be ignored.
        wr_bytes[0] = 8'h5A;
        wr_bytes[1] = 8'hC3;
        run_txn(8'h0A, 6'h1F, 4'd2, 30);

        slave_data[0] = 8'($urandom);
        run_txn(8'h0B, 6'($urandom), 4'd0, -1);

        // Reset in the middle of a write.
        d0 = done_cnt;
        @(negedge clk);
        start  = 1'b1;
        cmd    = 8'h0A;
        addr   = 6'h2D;
        length = 4'd1;
        t0     = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && (cyc - t0) < 50; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cycle", cyc - t0, 51);
        chk("midrst_ncs", nCS, 1);
        chk("midrst_sclk", SCLK, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        rd_cnt = 0;
        ncs_low = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!nCS) ncs_low++;
        end
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_rd_valid", rd_cnt, 0);
        chk("midrst_ncs_stays_high", ncs_low, 0);
        exp_mosi_q.delete();
        exp_rd_q.delete();
        wr_src_q.delete();

`ifdef ADXL362_CTRL_CMD_CHECK_EN
        e0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        cmd   = 8'h55;
        addr  = 6'h12;
        length = 4'd2;
        t0    = cyc;
        ncs_low = 0;
        busy_hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!nCS) ncs_low++;
            if (busy) busy_hi++;
        end
        chk("badcmd_err_count", err_cnt - e0, 1);
        chk("badcmd_err_cycle", err_rel, 1);
        chk("badcmd_ncs_high", ncs_low, 0);
        chk("badcmd_busy_low", busy_hi, 0);
`else
        e0 = err_cnt;
        busy_hi = 0;
        slave_data[0] = 8'h9C;
        slave_data[1] = 8'h3E;
        run_txn(8'h55, 6'h12, 4'd2, -1);
        chk("anycmd_no_err", err_cnt - e0, 0);
        chk("anycmd_err_total", err_cnt + busy_hi, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
